// File: rtl/knn_vote_pkg.sv
// knn_vote_pkg: shared FSM encoding, the no-winner label and width helpers
// for the k-NN result reader / vote classifier.
package knn_vote_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_READ,
        ST_LAST,
        ST_SCAN,
        ST_DONE
    } state_t;

    // Reported label when no valid vote was cast.
    localparam logic [7:0] NO_WINNER = 8'hFF;

    // Vote counter width: must hold hw_k itself, since every neighbour can vote for one class.
    function automatic int vote_width(input int hw_k);
        return $clog2(hw_k + 1);
    endfunction

    // Rank index width (0..hw_k-1), kept at least 1 bit.
    function automatic int rank_width(input int hw_k);
        return (hw_k > 2) ? $clog2(hw_k) : 1;
    endfunction

    // Class index width (0..n_classes-1), kept at least 1 bit.
    function automatic int class_width(input int n_classes);
        return (n_classes > 2) ? $clog2(n_classes) : 1;
    endfunction

endpackage

// File: rtl/knn_vote_hist.sv
// knn_vote_hist: per-class vote counters and first-vote ranks, with a
// synchronous clear, an accumulate port and a combinational read-by-index port.
module knn_vote_hist
    import knn_vote_pkg::*;
#(
    parameter  int HW_K      = 10,
    parameter  int N_CLASSES = 8,
    localparam int VOTE_W    = vote_width(HW_K),
    localparam int RANK_W    = rank_width(HW_K),
    localparam int CLS_W     = class_width(N_CLASSES)
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              acc_en,
    input  logic [CLS_W-1:0]  acc_idx,
    input  logic [RANK_W-1:0] acc_rank,
    input  logic [CLS_W-1:0]  rd_idx,
    output logic [VOTE_W-1:0] rd_votes,
    output logic [RANK_W-1:0] rd_first
);

    localparam logic [VOTE_W-1:0] VOTE_ONE = VOTE_W'(1);

    logic [VOTE_W-1:0] votes [N_CLASSES];
    logic [RANK_W-1:0] first [N_CLASSES];

    // Clear all classes, or count one valid vote and remember the rank of its first vote.
    // NOTE: the arrays get no reset; the FSM always passes through CLEAR before they are read.
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < N_CLASSES; i++) begin
                votes[i] <= '0;
                first[i] <= '0;
            end
        end else if (acc_en) begin
            votes[acc_idx] <= votes[acc_idx] + VOTE_ONE;
            if (votes[acc_idx] == '0) begin
                first[acc_idx] <= acc_rank;
            end
        end
    end

    assign rd_votes = votes[rd_idx];
    assign rd_first = first[rd_idx];

endmodule

// File: rtl/knn_vote.sv
// knn_vote: walks the sorter result port for k_eff ranks, builds a class
// histogram and reports the majority class (ties go to the nearest first vote).
// LABEL_IN is used directly (no extra register), so done arrives in cycle
// k_eff + 3 + N_CLASSES after the edge that accepts start.
module knn_vote
    import knn_vote_pkg::*;
#(
    parameter int HW_K      = 10,
    parameter int N_CLASSES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] K,
    output logic [15:0] SEL,
    input  logic [7:0]  LABEL_IN,
    output logic        busy,
    output logic        done,
    output logic [7:0]  LABEL_OUT,
    output logic [15:0] VOTES_OUT,
    output logic [15:0] INVALID_OUT
);

    localparam int VOTE_W = vote_width(HW_K);
    localparam int RANK_W = rank_width(HW_K);
    localparam int CLS_W  = class_width(N_CLASSES);

    localparam logic [RANK_W-1:0] RANK_ONE = RANK_W'(1);
    localparam logic [RANK_W-1:0] RANK_MAX = RANK_W'(HW_K - 1);
    localparam logic [CLS_W-1:0]  CLS_ONE  = CLS_W'(1);
    localparam logic [CLS_W-1:0]  CLS_LAST = CLS_W'(N_CLASSES - 1);

    state_t            state;
    logic [RANK_W-1:0] sel;
    logic [RANK_W-1:0] k_last;
    logic [CLS_W-1:0]  scan_idx;

    logic [VOTE_W-1:0] best_votes;
    logic [RANK_W-1:0] best_first;
    logic [7:0]        best_label;

    logic              label_valid;
    logic              accumulate;
    logic [RANK_W-1:0] acc_rank;
    logic [VOTE_W-1:0] rd_votes;
    logic [RANK_W-1:0] rd_first;

    logic              take;
    logic [VOTE_W-1:0] nxt_votes;
    logic [RANK_W-1:0] nxt_first;
    logic [7:0]        nxt_label;

    assign SEL = 16'(sel);

    // The label on LABEL_IN belongs to the SEL of the previous cycle.
    assign label_valid = (9'(LABEL_IN) < 9'(N_CLASSES));
    assign accumulate  = ((state == ST_READ) && (sel != '0)) || (state == ST_LAST);
    assign acc_rank    = (state == ST_LAST) ? sel : (sel - RANK_ONE);

    knn_vote_hist #(
        .HW_K      (HW_K),
        .N_CLASSES (N_CLASSES)
    ) u_hist (
        .clk      (clk),
        .clear    (state == ST_CLEAR),
        .acc_en   (accumulate && label_valid),
        .acc_idx  (LABEL_IN[CLS_W-1:0]),
        .acc_rank (acc_rank),
        .rd_idx   (scan_idx),
        .rd_votes (rd_votes),
        .rd_first (rd_first)
    );

    // Argmax step: decide whether the class being scanned replaces the running best.
    // NOTE: every output gets a default first so no path leaves a latch behind.
    always_comb begin
        take      = 1'b0;
        nxt_votes = best_votes;
        nxt_first = best_first;
        nxt_label = best_label;
        if (rd_votes > best_votes) begin
            take = 1'b1;
        end else if ((rd_votes == best_votes) && (rd_votes != '0) && (rd_first < best_first)) begin
            take = 1'b1;
        end
        if (take) begin
            nxt_votes = rd_votes;
            nxt_first = rd_first;
            nxt_label = 8'(scan_idx);
        end
    end

    // Control FSM with SEL counter, invalid counter, argmax and registered outputs.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            sel         <= '0;
            k_last      <= '0;
            scan_idx    <= '0;
            best_votes  <= '0;
            best_first  <= '0;
            best_label  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            LABEL_OUT   <= NO_WINNER;
            VOTES_OUT   <= '0;
            INVALID_OUT <= '0;
        end else begin
            done <= 1'b0;
            if (accumulate && !label_valid) begin
                INVALID_OUT <= INVALID_OUT + 16'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if ((K == 16'd0) || (K > 16'(HW_K))) begin
                            k_last <= RANK_MAX;
                        end else begin
                            k_last <= RANK_W'(K - 16'd1);
                        end
                        busy  <= 1'b1;
                        state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    sel         <= '0;
                    scan_idx    <= '0;
                    best_votes  <= '0;
                    best_first  <= '0;
                    best_label  <= '0;
                    LABEL_OUT   <= NO_WINNER;
                    VOTES_OUT   <= '0;
                    INVALID_OUT <= '0;
                    state       <= ST_READ;
                end
                ST_READ: begin
                    if (sel == k_last) begin
                        state <= ST_LAST;
                    end else begin
                        sel <= sel + RANK_ONE;
                    end
                end
                ST_LAST: begin
                    state <= ST_SCAN;
                end
                ST_SCAN: begin
                    best_votes <= nxt_votes;
                    best_first <= nxt_first;
                    best_label <= nxt_label;
                    if (scan_idx == CLS_LAST) begin
                        done      <= 1'b1;
                        LABEL_OUT <= (nxt_votes == '0) ? NO_WINNER : nxt_label;
                        VOTES_OUT <= 16'(nxt_votes);
                        state     <= ST_DONE;
                    end else begin
                        scan_idx <= scan_idx + CLS_ONE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_knn_vote.sv
// tb_knn_vote: directed and randomised checks of the k-NN vote classifier
// against hand-computed values and a rank-ordered reference model.
module tb_knn_vote;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] k_in;
    logic [15:0] sel;
    logic [7:0]  label_in;
    logic        busy;
    logic        done;
    logic [7:0]  label_out;
    logic [15:0] votes_out;
    logic [15:0] invalid_out;

    logic [7:0]  mem [16];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    // Sorter result port: one-cycle read latency.
    always @(posedge clk) label_in <= mem[sel[3:0]];

    knn_vote #(
        .HW_K      (10),
        .N_CLASSES (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .K           (k_in),
        .SEL         (sel),
        .LABEL_IN    (label_in),
        .busy        (busy),
        .done        (done),
        .LABEL_OUT   (label_out),
        .VOTES_OUT   (votes_out),
        .INVALID_OUT (invalid_out)
    );

    // Raise start for one sampling edge.
    task automatic pulse_start(input logic [15:0] k);
        @(negedge clk);
        start = 1'b1;
        k_in  = k;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Start a run and wait (bounded) for done; lat is the cycle index of done, -1 on timeout.
    task automatic run_one(input logic [15:0] k, output int lat, output int sel_max);
        pulse_start(k);
        lat     = -1;
        sel_max = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (int'(sel) > sel_max) sel_max = int'(sel);
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    // Reference: count over ranks, majority wins, ties go to the class seen first in rank order.
    task automatic ref_model(input logic [15:0] k, output logic [7:0] lab,
                             output logic [15:0] vts, output logic [15:0] inv, output int keff);
        int cnt [8];
        int maxv;
        keff = ((k == 16'd0) || (k > 16'd10)) ? 10 : int'(k);
        foreach (cnt[i]) cnt[i] = 0;
        inv  = 16'd0;
        maxv = 0;
        for (int r = 0; r < keff; r++) begin
            if (mem[r] < 8'd8) cnt[mem[r][2:0]]++;
            else inv++;
        end
        foreach (cnt[i]) if (cnt[i] > maxv) maxv = cnt[i];
        lab = 8'hFF;
        vts = 16'd0;
        if (maxv > 0) begin
            for (int r = 0; r < keff; r++) begin
                if ((mem[r] < 8'd8) && (cnt[mem[r][2:0]] == maxv)) begin
                    lab = mem[r];
                    vts = 16'(maxv);
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        k_in  = 16'd0;
        foreach (mem[i]) mem[i] = 8'd0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({busy, done} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_flags busy/done got %b%b want 00", busy, done);
        end
        tests_run++;
        if (sel !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_sel got %0d want 0", sel);
        end
        tests_run++;
        if ({label_out, votes_out, invalid_out} !== {8'hFF, 16'd0, 16'd0}) begin
            tests_failed++;
            $display("FAIL reset_outputs got label=%h votes=%0d invalid=%0d want ff/0/0",
                     label_out, votes_out, invalid_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_majority();
        int lat, smax;
        mem = '{8'd2, 8'd2, 8'd1, 8'd2, 8'd3, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4,
                8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4};
        run_one(16'd5, lat, smax);
        tests_run++;
        if (lat !== 16) begin
            tests_failed++;
            $display("FAIL majority_latency got %0d want 16", lat);
        end
        tests_run++;
        if ({label_out, votes_out, invalid_out} !== {8'd2, 16'd3, 16'd0}) begin
            tests_failed++;
            $display("FAIL majority_result got label=%0d votes=%0d invalid=%0d want 2/3/0",
                     label_out, votes_out, invalid_out);
        end
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL majority_busy_in_done got %b want 1", busy);
        end
    endtask

    task automatic test_tie();
        int lat, smax;
        mem = '{8'd3, 8'd5, 8'd5, 8'd3, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5,
                8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5};
        run_one(16'd4, lat, smax);
        tests_run++;
        if (lat !== 15) begin
            tests_failed++;
            $display("FAIL tie_latency got %0d want 15", lat);
        end
        tests_run++;
        if ({label_out, votes_out} !== {8'd3, 16'd2}) begin
            tests_failed++;
            $display("FAIL tie_result got label=%0d votes=%0d want 3/2", label_out, votes_out);
        end
    endtask

    task automatic test_clamp_invalid();
        int lat, smax;
        // With 8 classes the labels 9, 200 and 201 are all out of range: 5 invalid of 10.
        mem = '{8'd9, 8'd9, 8'd0, 8'd0, 8'd0, 8'd7, 8'd200, 8'd201, 8'd0, 8'd9,
                8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3};
        run_one(16'd0, lat, smax);
        tests_run++;
        if ((lat !== 21) || (smax !== 9)) begin
            tests_failed++;
            $display("FAIL clamp_k0_sweep got latency=%0d sel_max=%0d want 21/9", lat, smax);
        end
        tests_run++;
        if ({label_out, votes_out, invalid_out} !== {8'd0, 16'd4, 16'd5}) begin
            tests_failed++;
            $display("FAIL clamp_k0_result got label=%0d votes=%0d invalid=%0d want 0/4/5",
                     label_out, votes_out, invalid_out);
        end
        run_one(16'd15, lat, smax);
        tests_run++;
        if ((lat !== 21) || ({label_out, votes_out, invalid_out} !== {8'd0, 16'd4, 16'd5})) begin
            tests_failed++;
            $display("FAIL clamp_k15 got latency=%0d label=%0d votes=%0d invalid=%0d want 21/0/4/5",
                     lat, label_out, votes_out, invalid_out);
        end
    endtask

    task automatic test_all_invalid();
        int lat, smax;
        mem = '{8'd8, 8'd255, 8'd100, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1,
                8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
        run_one(16'd3, lat, smax);
        tests_run++;
        if ((lat !== 14) || ({label_out, votes_out, invalid_out} !== {8'hFF, 16'd0, 16'd3})) begin
            tests_failed++;
            $display("FAIL all_invalid got latency=%0d label=%h votes=%0d invalid=%0d want 14/ff/0/3",
                     lat, label_out, votes_out, invalid_out);
        end
    endtask

    task automatic test_handshake();
        int       ndone = 0;
        int       lat   = -1;
        logic [7:0]  lab = 8'h00;
        logic [15:0] vts = 16'd0;
        mem = '{8'd4, 8'd4, 8'd6, 8'd6, 8'd4, 8'd6, 8'd6, 8'd6, 8'd6, 8'd6,
                8'd6, 8'd6, 8'd6, 8'd6, 8'd6, 8'd6};
        pulse_start(16'd5);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if ((c == 2) || (c == 6)) begin
                start = 1'b1;
                k_in  = 16'd2;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat = c;
                    lab = label_out;
                    vts = votes_out;
                end
            end
        end
        start = 1'b0;
        tests_run++;
        if ((ndone !== 1) || (lat !== 16)) begin
            tests_failed++;
            $display("FAIL handshake_single_done got dones=%0d latency=%0d want 1/16", ndone, lat);
        end
        tests_run++;
        if ({lab, vts} !== {8'd4, 16'd3}) begin
            tests_failed++;
            $display("FAIL handshake_k_held got label=%0d votes=%0d want 4/3", lab, vts);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL handshake_idle_busy got %b want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int lat, smax;
        mem = '{8'd2, 8'd2, 8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
                8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        run_one(16'd5, lat, smax);
        tests_run++;
        if ((lat !== 16) || ({label_out, votes_out} !== {8'd2, 16'd3})) begin
            tests_failed++;
            $display("FAIL b2b_first got latency=%0d label=%0d votes=%0d want 16/2/3",
                     lat, label_out, votes_out);
        end
        // Start lands in the cycle right after done.
        mem = '{8'd6, 8'd0, 8'd6, 8'd0, 8'd1, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9,
                8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9};
        run_one(16'd5, lat, smax);
        tests_run++;
        if ((lat !== 16) || ({label_out, votes_out, invalid_out} !== {8'd6, 16'd2, 16'd0})) begin
            tests_failed++;
            $display("FAIL b2b_second got latency=%0d label=%0d votes=%0d invalid=%0d want 16/6/2/0",
                     lat, label_out, votes_out, invalid_out);
        end
    endtask

    task automatic test_reset_mid_read();
        int ndone = 0;
        int lat, smax;
        mem = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1,
                8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
        pulse_start(16'd6);
        // Cycle 1 is CLEAR, cycles 2..4 are the first three READ cycles.
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({busy, done, sel, label_out} !== {1'b0, 1'b0, 16'd0, 8'hFF}) begin
            tests_failed++;
            $display("FAIL reset_mid_read got busy=%b done=%b sel=%0d label=%h want 0/0/0/ff",
                     busy, done, sel, label_out);
        end
        rst = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        tests_run++;
        if (ndone !== 0) begin
            tests_failed++;
            $display("FAIL reset_no_partial got dones=%0d want 0", ndone);
        end
        mem = '{8'd5, 8'd1, 8'd5, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1,
                8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
        run_one(16'd3, lat, smax);
        tests_run++;
        if ((lat !== 14) || ({label_out, votes_out, invalid_out} !== {8'd5, 16'd2, 16'd0})) begin
            tests_failed++;
            $display("FAIL reset_then_run got latency=%0d label=%0d votes=%0d invalid=%0d want 14/5/2/0",
                     lat, label_out, votes_out, invalid_out);
        end
    endtask

    task automatic test_scoreboard();
        logic [15:0] k;
        logic [7:0]  exp_lab;
        logic [15:0] exp_vts, exp_inv;
        int keff, lat, smax, mode, p;
        for (int t = 0; t < 500; t++) begin
            k    = 16'($urandom_range(0, 15));
            mode = $urandom_range(0, 2);
            for (int r = 0; r < 16; r++) begin
                p = $urandom_range(0, 99);
                if (p < 12)         mem[r] = 8'($urandom_range(8, 255));
                else if (mode == 0) mem[r] = 8'($urandom_range(0, 1));
                else if (mode == 1) mem[r] = 8'($urandom_range(0, 3));
                else                mem[r] = 8'($urandom_range(0, 7));
            end
            ref_model(k, exp_lab, exp_vts, exp_inv, keff);
            run_one(k, lat, smax);
            tests_run++;
            if (lat !== keff + 11) begin
                tests_failed++;
                $display("FAIL sb_latency run=%0d k=%0d got %0d want %0d", t, k, lat, keff + 11);
            end
            tests_run++;
            if ({label_out, votes_out, invalid_out} !== {exp_lab, exp_vts, exp_inv}) begin
                tests_failed++;
                $display("FAIL sb_result run=%0d k=%0d got label=%h votes=%0d invalid=%0d want %h/%0d/%0d",
                         t, k, label_out, votes_out, invalid_out, exp_lab, exp_vts, exp_inv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_majority();
        test_tie();
        test_clamp_invalid();
        test_all_invalid();
        test_handshake();
        test_back_to_back();
        test_reset_mid_read();
        test_scoreboard();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
